// File: rtl/ta_ldd_pkg.sv
// Shared definitions for the laser-diode-driver command path: default widths
// and the scheduler state encoding, so the driver and the scheduler agree.
package ta_ldd_pkg;

    localparam int TOP0_0 = 3;
    localparam int LDD0_0 = 32;
    localparam int GAP_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPEN  = 3'd1,
        S_RUN   = 3'd2,
        S_CLOSE = 3'd3,
        S_GAP   = 3'd4
    } state_t;

endpackage

// File: rtl/ta_rr_arb.sv
// Combinational round-robin picker: one-hot grant on the first set request
// found searching upward from ptr, wrapping at NREQ-1.
module ta_rr_arb #(
    parameter int  NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    localparam logic [IW:0] NREQ_L = (IW+1)'(NREQ);

    logic [IW:0]   sum_s;
    logic [IW-1:0] idx_s;
    logic          found_s;

    // Walk the requesters starting at ptr and keep only the first hit.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        sum_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum_s        = {1'b0, ptr} + (IW+1)'(i);
            sum_s        = (sum_s >= NREQ_L) ? (sum_s - NREQ_L) : sum_s;
            idx_s        = sum_s[IW-1:0];
            grant[idx_s] = grant[idx_s] | (req[idx_s] & ~found_s);
            found_s      = found_s | req[idx_s];
        end
    end

endmodule

// File: rtl/ta_ldd_sched.sv
// Round-robin scheduler sharing one laser-diode-driver command port: grants one
// request at a time, strobes open/close, and enforces a guard gap between bursts.
module ta_ldd_sched #(
    parameter int  NREQ   = 4,
    parameter int  TOP0_0 = ta_ldd_pkg::TOP0_0,
    parameter int  LDD0_0 = ta_ldd_pkg::LDD0_0,
    parameter int  GAP_W  = ta_ldd_pkg::GAP_W,
    localparam int IW     = $clog2(NREQ)
) (
    input  logic                     clk200,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*TOP0_0-1:0]   req_wdis,
    input  logic [NREQ*LDD0_0-1:0]   req_plus,
    input  logic [NREQ-1:0]          req_abort,
    input  logic [GAP_W-1:0]         gap_cycles,
    output logic [TOP0_0-1:0]        com_wdis,
    output logic [LDD0_0-1:0]        com_plus,
    output logic                     com_open,
    output logic                     com_close,
    output logic [IW-1:0]            grant_id,
    output logic                     busy,
    output logic                     done
);

    import ta_ldd_pkg::state_t;
    import ta_ldd_pkg::S_IDLE;
    import ta_ldd_pkg::S_OPEN;
    import ta_ldd_pkg::S_RUN;
    import ta_ldd_pkg::S_CLOSE;
    import ta_ldd_pkg::S_GAP;

    state_t              state_r;
    state_t              state_next_s;
    logic [IW-1:0]       ptr_r;
    logic [LDD0_0-1:0]   cnt_r;
    logic [GAP_W-1:0]    gcnt_r;
    logic [TOP0_0-1:0]   com_wdis_r;
    logic [LDD0_0-1:0]   com_plus_r;
    logic                com_open_r;
    logic                com_close_r;
    logic [IW-1:0]       grant_id_r;
    logic                busy_r;
    logic                done_r;

    logic [NREQ-1:0]     grant_s;
    logic                accept_s;
    logic [IW-1:0]       win_idx_s;
    logic [IW-1:0]       ptr_next_s;
    logic [TOP0_0-1:0]   win_wdis_s;
    logic [LDD0_0-1:0]   win_plus_s;
    logic                abort_own_s;
    logic                run_last_s;
    logic                gap_zero_s;

    ta_rr_arb #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_r),
        .grant (grant_s)
    );

    assign req_ready = (state_r == S_IDLE) ? grant_s : '0;
    assign accept_s  = (state_r == S_IDLE) && (|req_valid);

    // Encode the winner and mux out its width code and pulse count.
    always_comb begin
        win_idx_s  = '0;
        win_wdis_s = '0;
        win_plus_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            win_idx_s = grant_s[i] ? IW'(i) : win_idx_s;
        end
        for (int i = 0; i < NREQ; i++) begin
            win_wdis_s = (win_idx_s == IW'(i)) ? req_wdis[i*TOP0_0 +: TOP0_0] : win_wdis_s;
            win_plus_s = (win_idx_s == IW'(i)) ? req_plus[i*LDD0_0 +: LDD0_0] : win_plus_s;
        end
    end

    assign ptr_next_s  = (win_idx_s == IW'(NREQ-1)) ? '0 : (win_idx_s + IW'(1));
    assign abort_own_s = req_abort[grant_id_r];
    // Natural completion outranks a coincident abort; an open-ended burst keeps cnt at 0.
    assign run_last_s  = (cnt_r == LDD0_0'(1));
    assign gap_zero_s  = (gap_cycles == '0);

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_next_s = S_OPEN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_OPEN: state_next_s = S_RUN;
            S_RUN: begin
                if (run_last_s) begin
                    state_next_s = gap_zero_s ? S_IDLE : S_GAP;
                end else if (abort_own_s) begin
                    state_next_s = S_CLOSE;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_CLOSE: state_next_s = gap_zero_s ? S_IDLE : S_GAP;
            S_GAP: begin
                if (gcnt_r == GAP_W'(1)) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_GAP;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register, counters and registered command outputs.
    always_ff @(posedge clk200 or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            ptr_r       <= '0;
            cnt_r       <= '0;
            gcnt_r      <= '0;
            com_wdis_r  <= '0;
            com_plus_r  <= '0;
            com_open_r  <= 1'b0;
            com_close_r <= 1'b0;
            grant_id_r  <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            busy_r      <= (state_next_s != S_IDLE);
            com_open_r  <= 1'b0;
            com_close_r <= 1'b0;
            done_r      <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        com_wdis_r <= win_wdis_s;
                        com_plus_r <= win_plus_s;
                        grant_id_r <= win_idx_s;
                        ptr_r      <= ptr_next_s;
                        com_open_r <= 1'b1;
                    end
                end
                S_OPEN: cnt_r <= com_plus_r;
                S_RUN: begin
                    if (run_last_s) begin
                        done_r <= 1'b1;
                        gcnt_r <= gap_cycles;
                    end else if (abort_own_s) begin
                        com_close_r <= 1'b1;
                    end else if (cnt_r != '0) begin
                        cnt_r <= cnt_r - LDD0_0'(1);
                    end
                end
                S_CLOSE: begin
                    done_r <= 1'b1;
                    gcnt_r <= gap_cycles;
                end
                S_GAP: gcnt_r <= gcnt_r - GAP_W'(1);
                default: ;
            endcase
        end
    end

    assign com_wdis  = com_wdis_r;
    assign com_plus  = com_plus_r;
    assign com_open  = com_open_r;
    assign com_close = com_close_r;
    assign grant_id  = grant_id_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_ta_ldd_sched.sv
// Directed bench for ta_ldd_sched: reset, arbitration order, counted and
// open-ended bursts, abort corner cases and asynchronous reset mid-burst.
`timescale 1ns/1ps
module tb_ta_ldd_sched;

    logic         clk200 = 1'b0;
    logic         rst_n  = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [11:0]  req_wdis  = '0;
    logic [127:0] req_plus  = '0;
    logic [3:0]   req_abort = '0;
    logic [15:0]  gap_cycles = '0;
    logic [2:0]   com_wdis;
    logic [31:0]  com_plus;
    logic         com_open, com_close, busy, done;
    logic [1:0]   grant_id;

    int pass_cnt = 0;
    int total_cnt = 0;
    int n_busy, n_open, n_close, n_done, first_close, first_done;
    logic [3:0] ab_sched [0:63];

    always #5 clk200 = ~clk200;

    ta_ldd_sched #(.NREQ(4), .TOP0_0(3), .LDD0_0(32), .GAP_W(16)) dut (
        .clk200     (clk200),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wdis   (req_wdis),
        .req_plus   (req_plus),
        .req_abort  (req_abort),
        .gap_cycles (gap_cycles),
        .com_wdis   (com_wdis),
        .com_plus   (com_plus),
        .com_open   (com_open),
        .com_close  (com_close),
        .grant_id   (grant_id),
        .busy       (busy),
        .done       (done)
    );

    task automatic clr_sched();
        for (int k = 0; k < 64; k++) ab_sched[k] = 4'b0000;
    endtask

    task automatic set_req(input int id, input logic [2:0] w, input logic [31:0] p);
        req_wdis[id*3 +: 3]  = w;
        req_plus[id*32 +: 32] = p;
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the OPEN cycle.
    task automatic start(input int id, input logic [15:0] g);
        gap_cycles = g;
        req_valid  = 4'b0001 << id;
        @(negedge clk200);
        req_valid  = 4'b0000;
    endtask

    // Samples ncyc cycles from the OPEN cycle (index 0), applying ab_sched.
    task automatic watch(input int ncyc);
        n_busy = 0; n_open = 0; n_close = 0; n_done = 0;
        first_close = -1; first_done = -1;
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) @(negedge clk200);
            if (busy === 1'b1) n_busy++;
            if (com_open === 1'b1) n_open++;
            if (com_close === 1'b1) begin
                n_close++;
                if (first_close < 0) first_close = k;
            end
            if (done === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
            req_abort = ab_sched[k];
        end
        req_abort = 4'b0000;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(negedge clk200);
            k++;
        end
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL %s_idle: busy=%b expected 0 within 200 cycles", name, busy);
        else pass_cnt++;
        @(negedge clk200);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk200);
        total_cnt++;
        if ({busy, com_open, com_close, done, grant_id, com_wdis, req_ready} !== 13'd0)
            $display("FAIL reset_ctl: got %b expected 0", {busy, com_open, com_close, done, grant_id, com_wdis, req_ready});
        else pass_cnt++;
        total_cnt++;
        if (com_plus !== 32'd0) $display("FAIL reset_plus: got %0d expected 0", com_plus);
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk200);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int got, t, last_t;
        for (int i = 0; i < 4; i++) set_req(i, 3'(i + 1), 32'd2);
        gap_cycles = 16'd0;
        req_valid  = 4'b1111;
        got = 0; t = 0; last_t = -1;
        while (got < 5 && t < 100) begin
            @(negedge clk200);
            t++;
            if (com_open === 1'b1) begin
                total_cnt++;
                if (grant_id !== 2'(got % 4)) $display("FAIL rr_id%0d: got %0d expected %0d", got, grant_id, got % 4);
                else pass_cnt++;
                total_cnt++;
                if (com_wdis !== 3'(got % 4 + 1)) $display("FAIL rr_wdis%0d: got %0d expected %0d", got, com_wdis, got % 4 + 1);
                else pass_cnt++;
                if (last_t >= 0) begin
                    total_cnt++;
                    if (t - last_t != 4) $display("FAIL rr_spacing%0d: got %0d expected 4", got, t - last_t);
                    else pass_cnt++;
                end
                last_t = t;
                got++;
                if (got == 5) req_valid = 4'b0000;
            end
        end
        req_valid = 4'b0000;
        total_cnt++;
        if (got != 5) $display("FAIL rr_count: got %0d grants expected 5", got);
        else pass_cnt++;
        wait_idle("rr");
    endtask

    task automatic test_single();
        set_req(2, 3'd5, 32'd4);
        gap_cycles = 16'd3;
        req_valid  = 4'b0100;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b expected 0100", req_ready);
        else pass_cnt++;
        @(negedge clk200);
        req_valid = 4'b0000;
        total_cnt++;
        if ({com_open, grant_id, com_wdis} !== {1'b1, 2'd2, 3'd5})
            $display("FAIL single_open: got open=%b id=%0d wdis=%0d expected 1/2/5", com_open, grant_id, com_wdis);
        else pass_cnt++;
        total_cnt++;
        if (com_plus !== 32'd4) $display("FAIL single_plus: got %0d expected 4", com_plus);
        else pass_cnt++;
        clr_sched();
        watch(20);
        total_cnt++;
        if (n_busy != 8) $display("FAIL single_busy: got %0d cycles expected 8", n_busy);
        else pass_cnt++;
        total_cnt++;
        if (n_open != 1 || n_close != 0) $display("FAIL single_strobes: got open=%0d close=%0d expected 1/0", n_open, n_close);
        else pass_cnt++;
        total_cnt++;
        if (n_done != 1 || first_done != 5) $display("FAIL single_done: got n=%0d at %0d expected 1 at 5", n_done, first_done);
        else pass_cnt++;
        wait_idle("single");
    endtask

    task automatic test_open_abort();
        set_req(1, 3'd3, 32'd0);
        clr_sched();
        ab_sched[10] = 4'b0010;
        start(1, 16'd2);
        total_cnt++;
        if ({com_open, grant_id} !== {1'b1, 2'd1}) $display("FAIL oe_open: got open=%b id=%0d expected 1/1", com_open, grant_id);
        else pass_cnt++;
        watch(30);
        total_cnt++;
        if (n_close != 1 || first_close != 11) $display("FAIL oe_close: got n=%0d at %0d expected 1 at 11", n_close, first_close);
        else pass_cnt++;
        total_cnt++;
        if (n_done != 1 || first_done != 12) $display("FAIL oe_done: got n=%0d at %0d expected 1 at 12", n_done, first_done);
        else pass_cnt++;
        total_cnt++;
        if (n_busy != 14) $display("FAIL oe_busy: got %0d cycles expected 14", n_busy);
        else pass_cnt++;
        wait_idle("oe");
    endtask

    task automatic test_abort_on_last();
        set_req(0, 3'd6, 32'd3);
        clr_sched();
        ab_sched[3] = 4'b0001;
        start(0, 16'd0);
        total_cnt++;
        if (grant_id !== 2'd0) $display("FAIL last_id: got %0d expected 0", grant_id);
        else pass_cnt++;
        watch(12);
        total_cnt++;
        if (n_close != 0) $display("FAIL last_close: got %0d close strobes expected 0", n_close);
        else pass_cnt++;
        total_cnt++;
        if (n_done != 1 || first_done != 4) $display("FAIL last_done: got n=%0d at %0d expected 1 at 4", n_done, first_done);
        else pass_cnt++;
        total_cnt++;
        if (n_busy != 4) $display("FAIL last_busy: got %0d cycles expected 4", n_busy);
        else pass_cnt++;
        wait_idle("last");
    endtask

    task automatic test_nonowner_abort();
        set_req(3, 3'd7, 32'd5);
        clr_sched();
        ab_sched[0] = 4'b1000;
        for (int k = 1; k <= 5; k++) ab_sched[k] = 4'b0001;
        ab_sched[6] = 4'b1000;
        ab_sched[8] = 4'b1000;
        start(3, 16'd1);
        total_cnt++;
        if (grant_id !== 2'd3) $display("FAIL nonown_id: got %0d expected 3", grant_id);
        else pass_cnt++;
        watch(14);
        total_cnt++;
        if (n_close != 0) $display("FAIL nonown_close: got %0d close strobes expected 0", n_close);
        else pass_cnt++;
        total_cnt++;
        if (n_done != 1 || first_done != 6) $display("FAIL nonown_done: got n=%0d at %0d expected 1 at 6", n_done, first_done);
        else pass_cnt++;
        total_cnt++;
        if (n_busy != 7) $display("FAIL nonown_busy: got %0d cycles expected 7", n_busy);
        else pass_cnt++;
        wait_idle("nonown");
    endtask

    task automatic test_reset_mid_run();
        set_req(2, 3'd5, 32'd20);
        start(2, 16'd0);
        repeat (5) @(negedge clk200);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL midrst_pre: busy=%b expected 1", busy);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, com_open, com_close, done, grant_id, com_wdis, req_ready} !== 13'd0)
            $display("FAIL midrst_ctl: got %b expected 0", {busy, com_open, com_close, done, grant_id, com_wdis, req_ready});
        else pass_cnt++;
        total_cnt++;
        if (com_plus !== 32'd0) $display("FAIL midrst_plus: got %0d expected 0", com_plus);
        else pass_cnt++;
        @(negedge clk200);
        rst_n = 1'b1;
        @(negedge clk200);
        set_req(0, 3'd2, 32'd1);
        gap_cycles = 16'd0;
        req_valid  = 4'b1111;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0001) $display("FAIL midrst_ready: got %b expected 0001", req_ready);
        else pass_cnt++;
        @(negedge clk200);
        req_valid = 4'b0000;
        total_cnt++;
        if ({com_open, grant_id, com_wdis} !== {1'b1, 2'd0, 3'd2})
            $display("FAIL midrst_grant: got open=%b id=%0d wdis=%0d expected 1/0/2", com_open, grant_id, com_wdis);
        else pass_cnt++;
        wait_idle("midrst");
    endtask

    initial begin
        clr_sched();
        test_reset();
        test_round_robin();
        test_single();
        test_open_abort();
        test_abort_on_last();
        test_nonowner_abort();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
